// File: rtl/mul_sched_pkg.sv
// -----------------------------------------------------------------------------
// mul_sched_pkg
// Shared definitions for the two-client multiplier scheduler:
//   - FSM state encoding (3-bit, IDLE=0 .. CLR=4)
//   - data width of operands and product
//   - default watchdog limit and the counter width that holds it
//   - helper that turns the watchdog limit into the counter value that trips it
// -----------------------------------------------------------------------------
package mul_sched_pkg;

    localparam int DATA_W      = 32;
    localparam int TIMEOUT_DEF = 31;
    // Wide enough for any TIMEOUT in 1..255.
    localparam int CNT_W       = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_CLR   = 3'd4
    } state_t;

    // The counter starts at 0 in the first WAIT cycle, so the TIMEOUT-th
    // WAIT cycle is the one where the counter reads TIMEOUT-1.
    function automatic logic [CNT_W-1:0] timeout_last(input int timeout);
        return CNT_W'(timeout - 1);
    endfunction

endpackage

// File: rtl/mul_sched_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Purely combinational two-way round-robin pick. The history bit is owned by
// the caller.
// Ports:
//   req0, req1  in   client requests
//   last        in   client served most recently (0 = client 0, 1 = client 1)
//   valid       out  at least one request is present
//   winner      out  selected client (0 or 1); meaningful only when valid
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic winner
);

    // Tie goes to the client that was not served last.
    always_comb begin
        valid = req0 | req1;
        if (req0 && req1) begin
            winner = ~last;
        end else if (req1) begin
            winner = 1'b1;
        end else begin
            winner = 1'b0;
        end
    end

endmodule

// File: rtl/mul_sched.sv
// -----------------------------------------------------------------------------
// mul_sched
// Shares one sequential multiplier core between two clients. A round-robin
// arbiter picks a client in IDLE, its operands are latched, the core is
// started, and the product is returned with a one-cycle done strobe. A
// watchdog aborts a job whose core never answers.
// Parameters:
//   TIMEOUT     WAIT cycles allowed before abort (1..255)
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   req0/req1, a0/b0/a1/b1  client requests and operands
//   gnt0/gnt1               one-cycle operand-accepted pulses
//   done0/done1             one-cycle result-valid pulses
//   result                  registered product, held between jobs
//   err                     one-cycle watchdog-abort pulse
//   busy                    high whenever the FSM is not IDLE
//   mul_start/mul_clear     core handshake strobes
//   mul_a/mul_b             latched operands to the core
//   mul_done/mul_result     core completion and product
// All outputs come straight from flops; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module mul_sched
    import mul_sched_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] result,
    output logic              err,
    output logic              busy,
    output logic              mul_start,
    output logic              mul_clear,
    output logic [DATA_W-1:0] mul_a,
    output logic [DATA_W-1:0] mul_b,
    input  logic              mul_done,
    input  logic [DATA_W-1:0] mul_result
);

    localparam logic [CNT_W-1:0] CNT_LAST = timeout_last(TIMEOUT);

    state_t           state;
    state_t           state_next;
    logic             owner;
    logic             last;
    logic [CNT_W-1:0] cnt;
    logic             arb_valid;
    logic             arb_winner;
    logic             grant;
    logic             timeout_hit;
    logic             job_done;

    rr_arb2 u_arb (
        .req0   (req0),
        .req1   (req1),
        .last   (last),
        .valid  (arb_valid),
        .winner (arb_winner)
    );

    assign grant       = (state == ST_IDLE) && arb_valid;
    assign job_done    = (state == ST_WAIT) && mul_done;
    assign timeout_hit = (cnt == CNT_LAST);

    // Next-state decode; mul_done wins over a coincident timeout.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_next = ST_START;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_START: state_next = ST_WAIT;
            ST_WAIT: begin
                if (mul_done) begin
                    state_next = ST_RESP;
                end else if (timeout_hit) begin
                    state_next = ST_CLR;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_RESP: state_next = ST_CLR;
            ST_CLR:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM state plus every strobe, registered so each lines up with the
    // state it belongs to (gnt/mul_start in START, done in RESP, clear in CLR).
    // err is registered off the timeout edge and so appears in the CLR cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            mul_start <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err       <= 1'b0;
            mul_clear <= 1'b0;
        end else begin
            state     <= state_next;
            busy      <= (state_next != ST_IDLE);
            gnt0      <= grant && !arb_winner;
            gnt1      <= grant && arb_winner;
            mul_start <= grant;
            done0     <= job_done && !owner;
            done1     <= job_done && owner;
            err       <= (state == ST_WAIT) && !mul_done && timeout_hit;
            mul_clear <= (state_next == ST_CLR);
        end
    end

    // Owner of the current job and round-robin history; reset favours req0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner <= 1'b0;
            last  <= 1'b1;
        end else if (grant) begin
            owner <= arb_winner;
            last  <= arb_winner;
        end else begin
            owner <= owner;
            last  <= last;
        end
    end

    // Watchdog counter: cleared on the way into WAIT, advanced each idle WAIT cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= {CNT_W{1'b0}};
        end else if (state == ST_START) begin
            cnt <= {CNT_W{1'b0}};
        end else if ((state == ST_WAIT) && !mul_done && !timeout_hit) begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt <= cnt;
        end
    end

    // Operand latch on the grant edge; held until the next grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_a <= {DATA_W{1'b0}};
            mul_b <= {DATA_W{1'b0}};
        end else if (grant) begin
            mul_a <= arb_winner ? a1 : a0;
            mul_b <= arb_winner ? b1 : b0;
        end else begin
            mul_a <= mul_a;
            mul_b <= mul_b;
        end
    end

    // Product capture; untouched by aborts and by mul_done outside WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result <= {DATA_W{1'b0}};
        end else if (job_done) begin
            result <= mul_result;
        end else begin
            result <= result;
        end
    end

endmodule

// File: tb/tb_mul_sched.sv
// -----------------------------------------------------------------------------
// tb_mul_sched
// Directed bench for mul_sched. Two instances: dut (default TIMEOUT=31) and
// dut_wd (TIMEOUT=4) for the watchdog cases. A small core model answers each
// mul_start after a programmable number of WAIT cycles with mul_a*mul_b.
// -----------------------------------------------------------------------------
module tb_mul_sched;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    // Main instance signals
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] a0 = 32'd0, b0 = 32'd0, a1 = 32'd0, b1 = 32'd0;
    logic        gnt0, gnt1, done0, done1, err, busy, mul_start, mul_clear;
    logic [31:0] result, mul_a, mul_b;
    logic        mul_done;
    logic [31:0] mul_result;

    // Watchdog instance signals
    logic        w_req0 = 1'b0;
    logic [31:0] w_a0 = 32'd0;
    logic        w_gnt0, w_gnt1, w_done0, w_done1, w_err, w_busy, w_mul_start, w_mul_clear;
    logic [31:0] w_result, w_mul_a, w_mul_b;
    logic        w_mul_done;
    logic [31:0] w_mul_result;

    mul_sched dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .err(err), .busy(busy),
        .mul_start(mul_start), .mul_clear(mul_clear),
        .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_result(mul_result)
    );

    mul_sched #(.TIMEOUT(4)) dut_wd (
        .clk(clk), .reset(reset),
        .req0(w_req0), .req1(1'b0), .a0(w_a0), .b0(32'd9), .a1(32'd0), .b1(32'd0),
        .gnt0(w_gnt0), .gnt1(w_gnt1), .done0(w_done0), .done1(w_done1),
        .result(w_result), .err(w_err), .busy(w_busy),
        .mul_start(w_mul_start), .mul_clear(w_mul_clear),
        .mul_a(w_mul_a), .mul_b(w_mul_b),
        .mul_done(w_mul_done), .mul_result(w_mul_result)
    );

    // Core models: delay -1 means never answer; delay d means mul_done is
    // seen at the end of the d-th WAIT cycle.
    int          core_delay = -1;
    logic        core_done  = 1'b0;
    logic        spur_done  = 1'b0;
    logic [31:0] core_res   = 32'd0;
    assign mul_done   = core_done | spur_done;
    assign mul_result = core_res;

    initial begin
        forever begin
            @(negedge clk);
            if (mul_start && core_delay >= 0) begin
                repeat (core_delay) @(negedge clk);
                core_res  = mul_a * mul_b;
                core_done = 1'b1;
                @(negedge clk);
                core_done = 1'b0;
            end
        end
    end

    int          w_core_delay = -1;
    logic        w_core_done  = 1'b0;
    logic [31:0] w_core_res   = 32'd0;
    assign w_mul_done   = w_core_done;
    assign w_mul_result = w_core_res;

    initial begin
        forever begin
            @(negedge clk);
            if (w_mul_start && w_core_delay >= 0) begin
                repeat (w_core_delay) @(negedge clk);
                w_core_res  = w_mul_a * w_mul_b;
                w_core_done = 1'b1;
                @(negedge clk);
                w_core_done = 1'b0;
            end
        end
    end

    // Event recorder (no checking here), sampled 2 time units after each edge.
    int          cyc = 0;
    int          n_gnt1 = 0, n_done = 0, w_ndone = 0, w_nerr = 0;
    int          gnt_who[$];
    int          gnt_cyc[$];
    int          done_who[$];
    logic [31:0] done_res[$];

    always @(posedge clk) begin
        #2;
        cyc = cyc + 1;
        if (gnt0) begin gnt_who.push_back(0); gnt_cyc.push_back(cyc); end
        if (gnt1) begin gnt_who.push_back(1); gnt_cyc.push_back(cyc); n_gnt1 = n_gnt1 + 1; end
        if (done0) begin done_who.push_back(0); done_res.push_back(result); n_done = n_done + 1; end
        if (done1) begin done_who.push_back(1); done_res.push_back(result); n_done = n_done + 1; end
        if (w_done0) w_ndone = w_ndone + 1;
        if (w_err) w_nerr = w_nerr + 1;
    end

    int checks = 0;
    int errors = 0;

    function automatic logic sel_val(input int sel);
        case (sel)
            0: return gnt0;
            1: return gnt1;
            2: return done0;
            3: return done1;
            4: return w_gnt0;
            5: return w_done0;
            6: return gnt0 | gnt1;
            default: return 1'b0;
        endcase
    endfunction

    // Wait (at negedges) until the selected strobe is high; n = negedges waited.
    task automatic wait_for(input int sel, input int limit, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            n = n + 1;
            if (sel_val(sel)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt0, gnt1, done0, done1, err, busy, mul_start, mul_clear} !== 8'h00) begin
            errors++;
            $display("FAIL reset_strobes got %b want 00000000",
                     {gnt0, gnt1, done0, done1, err, busy, mul_start, mul_clear});
        end
        checks++;
        if ({result, mul_a, mul_b} !== 96'd0) begin
            errors++;
            $display("FAIL reset_data got result=%0d mul_a=%0d mul_b=%0d want 0", result, mul_a, mul_b);
        end
        checks++;
        if ({w_gnt0, w_gnt1, w_done0, w_done1, w_err, w_busy, w_mul_start, w_mul_clear} !== 8'h00
            || {w_result, w_mul_a, w_mul_b} !== 96'd0) begin
            errors++;
            $display("FAIL reset_wd got nonzero outputs, want all 0");
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy got %b want 0", busy);
        end
    endtask

    task automatic test_single;
        int n;
        bit ok;
        int g0;
        g0 = gnt_who.size();
        core_delay = 10;
        req0 = 1'b1; a0 = 32'd7; b0 = 32'd6;
        wait_for(0, 10, n, ok);
        // Client inputs change right after the grant and must be ignored.
        req0 = 1'b0; a0 = 32'd1000; b0 = 32'd1000;
        checks++;
        if (!ok || n != 1) begin
            errors++;
            $display("FAIL single_gnt got ok=%0d latency=%0d want ok=1 latency=1", ok, n);
        end
        checks++;
        if (mul_a !== 32'd7 || mul_b !== 32'd6 || mul_start !== 1'b1) begin
            errors++;
            $display("FAIL single_operands got a=%0d b=%0d start=%b want 7 6 1", mul_a, mul_b, mul_start);
        end
        wait_for(2, 30, n, ok);
        checks++;
        if (!ok || n != 11) begin
            errors++;
            $display("FAIL single_done got ok=%0d cycles=%0d want ok=1 cycles=11", ok, n);
        end
        checks++;
        if (result !== 32'd42 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL single_result got %0d done1=%b want 42 0", result, done1);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || mul_clear !== 1'b1 || mul_a !== 32'd7) begin
            errors++;
            $display("FAIL single_clr got busy=%b clr=%b a=%0d want 1 1 7", busy, mul_clear, mul_a);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mul_clear !== 1'b0 || gnt_who.size() != g0 + 1) begin
            errors++;
            $display("FAIL single_idle got busy=%b clr=%b grants=%0d want 0 0 1",
                     busy, mul_clear, gnt_who.size() - g0);
        end
    endtask

    task automatic test_min_latency;
        int n;
        bit ok;
        core_delay = 1;
        req1 = 1'b1; a1 = 32'd3; b1 = 32'd5;
        wait_for(1, 10, n, ok);
        req1 = 1'b0;
        checks++;
        if (!ok || n != 1) begin
            errors++;
            $display("FAIL minlat_gnt got ok=%0d latency=%0d want ok=1 latency=1", ok, n);
        end
        wait_for(3, 10, n, ok);
        checks++;
        if (!ok || n != 2 || result !== 32'd15) begin
            errors++;
            $display("FAIL minlat_done got ok=%0d cycles=%0d result=%0d want 1 2 15", ok, n, result);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int  gb;
        int  db;
        bit  ok;
        core_delay = 1;
        gb = gnt_who.size();
        db = done_who.size();
        a0 = 32'd2; b0 = 32'd3; a1 = 32'd4; b1 = 32'd5;
        req0 = 1'b1; req1 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (gnt_who.size() >= gb + 4) begin
                ok = 1'b1;
                break;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_grants got %0d grants want 4", gnt_who.size() - gb);
        end
        for (int i = 0; i < 20 && done_who.size() < db + 4; i++) @(negedge clk);
        checks++;
        if (done_who.size() < db + 4) begin
            errors++;
            $display("FAIL b2b_dones got %0d dones want 4", done_who.size() - db);
        end
        if (ok && done_who.size() >= db + 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (gnt_who[gb + i] != (i % 2)) begin
                    errors++;
                    $display("FAIL b2b_order[%0d] got client %0d want %0d", i, gnt_who[gb + i], i % 2);
                end
                checks++;
                if (done_who[db + i] != (i % 2) || done_res[db + i] !== ((i % 2) ? 32'd20 : 32'd6)) begin
                    errors++;
                    $display("FAIL b2b_result[%0d] got client %0d value %0d want client %0d value %0d",
                             i, done_who[db + i], done_res[db + i], i % 2, (i % 2) ? 20 : 6);
                end
                if (i > 0) begin
                    checks++;
                    if (gnt_cyc[gb + i] - gnt_cyc[gb + i - 1] != 5) begin
                        errors++;
                        $display("FAIL b2b_spacing[%0d] got %0d want 5", i,
                                 gnt_cyc[gb + i] - gnt_cyc[gb + i - 1]);
                    end
                end
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_watchdog;
        int n;
        bit ok;
        int nd;
        int ne;
        // Prior good job so result holds a known value.
        w_core_delay = 2;
        w_a0 = 32'd5; w_req0 = 1'b1;
        wait_for(4, 10, n, ok);
        w_req0 = 1'b0;
        wait_for(5, 10, n, ok);
        checks++;
        if (!ok || w_result !== 32'd45) begin
            errors++;
            $display("FAIL wd_prior got ok=%0d result=%0d want 1 45", ok, w_result);
        end
        repeat (2) @(negedge clk);
        // Core never answers.
        w_core_delay = -1;
        nd = w_ndone; ne = w_nerr;
        w_a0 = 32'd8; w_req0 = 1'b1;
        wait_for(4, 10, n, ok);
        w_req0 = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wd_gnt got no grant want grant");
        end
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            checks++;
            if (i <= 4) begin
                if (w_err !== 1'b0 || w_busy !== 1'b1 || w_mul_clear !== 1'b0) begin
                    errors++;
                    $display("FAIL wd_wait[%0d] got err=%b busy=%b clr=%b want 0 1 0", i, w_err, w_busy, w_mul_clear);
                end
            end else if (i == 5) begin
                if (w_err !== 1'b1 || w_mul_clear !== 1'b1 || w_done0 !== 1'b0) begin
                    errors++;
                    $display("FAIL wd_abort got err=%b clr=%b done=%b want 1 1 0", w_err, w_mul_clear, w_done0);
                end
            end else begin
                if (w_err !== 1'b0 || w_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL wd_idle got err=%b busy=%b want 0 0", w_err, w_busy);
                end
            end
        end
        checks++;
        if (w_result !== 32'd45 || w_ndone != nd || w_nerr != ne + 1) begin
            errors++;
            $display("FAIL wd_after got result=%0d dones=%0d errs=%0d want 45 0 1",
                     w_result, w_ndone - nd, w_nerr - ne);
        end
    endtask

    task automatic test_simultaneous;
        int n;
        bit ok;
        int ne;
        w_core_delay = 4;
        ne = w_nerr;
        w_a0 = 32'd3; w_req0 = 1'b1;
        wait_for(4, 10, n, ok);
        w_req0 = 1'b0;
        wait_for(5, 10, n, ok);
        checks++;
        if (!ok || n != 5 || w_result !== 32'd27) begin
            errors++;
            $display("FAIL simul_done got ok=%0d cycles=%0d result=%0d want 1 5 27", ok, n, w_result);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (w_nerr != ne) begin
            errors++;
            $display("FAIL simul_err got %0d err pulses want 0", w_nerr - ne);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        bit ok;
        core_delay = -1;
        a0 = 32'd11; b0 = 32'd11; req0 = 1'b1;
        wait_for(0, 10, n, ok);
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || result === 32'd0) begin
            errors++;
            $display("FAIL mid_pre got busy=%b result=%0d want busy=1 result nonzero", busy, result);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({gnt0, gnt1, done0, done1, err, busy, mul_start, mul_clear} !== 8'h00
            || {result, mul_a, mul_b} !== 96'd0) begin
            errors++;
            $display("FAIL mid_reset got busy=%b result=%0d mul_a=%0d want all 0", busy, result, mul_a);
        end
        core_delay = 1;
        a0 = 32'd2; b0 = 32'd2; a1 = 32'd9; b1 = 32'd9;
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_for(6, 10, n, ok);
        req0 = 1'b0; req1 = 1'b0;
        checks++;
        if (!ok || gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL mid_first got ok=%0d gnt0=%b gnt1=%b want 1 1 0", ok, gnt0, gnt1);
        end
        wait_for(2, 10, n, ok);
        checks++;
        if (!ok || result !== 32'd4) begin
            errors++;
            $display("FAIL mid_result got ok=%0d result=%0d want 1 4", ok, result);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_spurious;
        int nd;
        int ng;
        nd = n_done;
        ng = n_gnt1;
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || n_done != nd || result !== 32'd4) begin
            errors++;
            $display("FAIL spurious got busy=%b dones=%0d result=%0d want 0 0 4", busy, n_done - nd, result);
        end
        // Pulse req1 strictly between two rising edges.
        @(posedge clk);
        #1 req1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (n_gnt1 != ng || busy !== 1'b0) begin
            errors++;
            $display("FAIL withdrawn got gnt1 pulses=%0d busy=%b want 0 0", n_gnt1 - ng, busy);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_min_latency;
        test_back_to_back;
        test_watchdog;
        test_simultaneous;
        test_reset_mid;
        test_spurious;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout got no finish want finish before 100000");
        $fatal(1);
    end

endmodule
